// File: rtl/riscv_bu_bp_ctrl.sv
// riscv_bu_bp_ctrl: branch-unit side of the correlating predictor; carries the ID prediction into EX, owns global history, drives predictor update and mispredict.
// Optional macro RISCV_BP_STATS_EN builds resolved-branch and mispredict statistics counters.
module riscv_bu_bp_ctrl #(
  parameter int XLEN           = 32,
  parameter int HAS_BPU        = 0,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int STAT_BITS      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_stall_i,
  input  logic                      ex_flush_i,
  input  logic [1:0]                bp_bp_predict_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_stall_i,
  input  logic                      ex_is_branch_i,
  input  logic                      ex_btaken_i,
  output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
  output logic [1:0]                bu_bp_predict_o,
  output logic                      bu_bp_btaken_o,
  output logic                      bu_bp_update_o,
  output logic                      ex_bp_taken_o,
  output logic                      bu_mispredict_o,
  output logic [STAT_BITS-1:0]      bp_branch_cnt_o,
  output logic [STAT_BITS-1:0]      bp_mispredict_cnt_o
);
  logic [1:0]                r_ex_pred;
  logic [BP_GLOBAL_BITS-1:0] r_history;
  logic                      w_bpu;
  logic                      w_resolve;
  logic                      w_mispredict;
  if (XLEN < 1 || BP_GLOBAL_BITS < 1) begin : g_bad_cfg
  end
  assign w_bpu = HAS_BPU != 0;
  // Gating with rst_ni keeps every output low while reset is held.
  assign w_resolve    = rst_ni & ex_valid_i & ex_is_branch_i & ~ex_stall_i;
  assign w_mispredict = w_resolve & (r_ex_pred[1] ^ ex_btaken_i);
  assign bu_bp_history_o = r_history;
  assign bu_bp_predict_o = r_ex_pred;
  assign bu_bp_btaken_o  = rst_ni & ex_btaken_i;
  assign bu_bp_update_o  = w_resolve & w_bpu;
  assign ex_bp_taken_o   = r_ex_pred[1];
  assign bu_mispredict_o = w_mispredict;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex_pred <= 2'b00;
      r_history <= '0;
    end else begin
      r_ex_pred <= ex_flush_i ? 2'b00 : !id_stall_i ? (bp_bp_predict_i & {2{w_bpu}}) : r_ex_pred;
      // Truncating the concatenation drops the oldest bit; also covers a 1-bit history.
      if (w_resolve) r_history <= BP_GLOBAL_BITS'({r_history, ex_btaken_i});
    end
  end
`ifdef RISCV_BP_STATS_EN
  logic [STAT_BITS-1:0] r_branch_cnt;
  logic [STAT_BITS-1:0] r_mispredict_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_resolve) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
    end
  end
  assign bp_branch_cnt_o     = r_branch_cnt;
  assign bp_mispredict_cnt_o = r_mispredict_cnt;
`else
  assign bp_branch_cnt_o     = '0;
  assign bp_mispredict_cnt_o = '0;
`endif
endmodule
